// File: rtl/fcmp_s_unit.sv
// fcmp_s_unit
//   Two-stage pipelined binary32 compare unit (FEQ.S / FLT.S / FLE.S).
//   S1 registers the request (operands, op, tag); S2 is the output register.
//   A valid/ready handshake is used on both sides, giving full throughput
//   and clean stalls under output backpressure.
//
//   Optional feature macro: FCMP_NAN_EN
//     defined   : exponent 255 with a nonzero mantissa is a NaN. Any NaN gives
//                 y=0. nv=1 for FLT/FLE with any NaN, and for FEQ only with a
//                 signaling NaN. Infinities order normally.
//     undefined : exponent 255 is ordered by bit pattern, and nv is tied to 0.
//
// Ports
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  request can be accepted this cycle
//   x1, x2     in   binary32 operands
//   op         in   00 FLE, 01 FLT, 10 FEQ, 11 reserved (y=0, nv=0)
//   tag_in     in   destination tag
//   out_valid  out  result present
//   out_ready  in   consumer accepts the result
//   y          out  comparison result
//   nv         out  invalid-operation flag
//   tag_out    out  tag of the current result
module fcmp_s_unit #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [1:0]       op,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y,
    output logic             nv,
    output logic [TAG_W-1:0] tag_out
);

    typedef enum logic [1:0] {
        OP_FLE = 2'b00,
        OP_FLT = 2'b01,
        OP_FEQ = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    // S1: request register
    logic             s1_valid_q;
    logic [31:0]      s1_x1_q;
    logic [31:0]      s1_x2_q;
    op_e              s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;

    // S2: output register
    logic             s2_valid_q;
    logic             y_q;
    logic [TAG_W-1:0] tag_q;

    logic             s2_load;
    logic             y_d;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             eq;
    logic             lt;

    assign s2_load   = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_load;
    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign tag_out   = tag_q;

`ifdef FCMP_NAN_EN
    logic nv_q;
    logic nv_d;
    logic a_nan;
    logic b_nan;
    logic a_snan;
    logic b_snan;

    assign a_nan  = (s1_x1_q[30:23] == 8'hFF) && (s1_x1_q[22:0] != '0);
    assign b_nan  = (s1_x2_q[30:23] == 8'hFF) && (s1_x2_q[22:0] != '0);
    assign a_snan = a_nan && !s1_x1_q[22];
    assign b_snan = b_nan && !s1_x2_q[22];
    assign nv     = nv_q;
`else
    assign nv     = 1'b0;
`endif

    always_comb begin
        // Zero exponent (zero or denormal) canonicalises to +0, which makes
        // the sign of a flushed value irrelevant to both eq and lt.
        a  = (s1_x1_q[30:23] == 8'd0) ? '0 : s1_x1_q;
        b  = (s1_x2_q[30:23] == 8'd0) ? '0 : s1_x2_q;
        eq = (a == b);
        if (a[31] != b[31]) begin
            lt = a[31];
        end else if (!a[31]) begin
            lt = (a[30:0] < b[30:0]);
        end else begin
            lt = (a[30:0] > b[30:0]);
        end

        unique case (s1_op_q)
            OP_FLE:  y_d = lt || eq;
            OP_FLT:  y_d = lt;
            OP_FEQ:  y_d = eq;
            default: y_d = 1'b0;
        endcase

`ifdef FCMP_NAN_EN
        nv_d = 1'b0;
        if (a_nan || b_nan) begin
            y_d = 1'b0;
            unique case (s1_op_q)
                OP_FLE, OP_FLT: nv_d = 1'b1;
                OP_FEQ:         nv_d = a_snan || b_snan;
                default:        nv_d = 1'b0;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_x1_q    <= '0;
            s1_x2_q    <= '0;
            s1_op_q    <= OP_FLE;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= 1'b0;
            tag_q      <= '0;
`ifdef FCMP_NAN_EN
            nv_q       <= 1'b0;
`endif
        end else begin
            // S2 data only changes when a real result moves in, so a bubble
            // leaves the last result's fields in place.
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    y_q   <= y_d;
                    tag_q <= s1_tag_q;
`ifdef FCMP_NAN_EN
                    nv_q  <= nv_d;
`endif
                end
            end
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_x1_q  <= x1;
                    s1_x2_q  <= x2;
                    s1_op_q  <= op_e'(op);
                    s1_tag_q <= tag_in;
                end
            end
        end
    end

endmodule

// File: doc/fcmp_s_unit.md
# fcmp_s_unit

Pipelined single-precision floating-point compare unit answering FEQ.S / FLT.S / FLE.S requests from the FPU issue stage. Unlike the purely combinational equality comparator, it sits behind a valid/ready handshake, registers operands, and returns a 1-bit result plus a destination tag to the writeback arbiter two cycles later. It sustains full throughput and stalls cleanly under output backpressure.

## Interface
Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside each request.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request this cycle.
- x1  in  32  operand 1, IEEE-754 binary32.
- x2  in  32  operand 2, IEEE-754 binary32.
- op  in  2  2'b00 FLE, 2'b01 FLT, 2'b10 FEQ, 2'b11 reserved.
- tag_in  in  TAG_W  destination tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- y  out  1  comparison result, 1 = true.
- nv  out  1  invalid-operation flag; see Configuration.
- tag_out  out  TAG_W  tag of the current result.

## Operation
- Two register stages: S1 holds the operands, op and tag; S2 is the output register (y, nv, tag_out, out_valid).
- Accept: the request is captured into S1 on an edge where in_valid && in_ready.
- Advance: S2 loads from S1 when s2_load = !s2_valid || out_ready. S1 empties or refills on the same edge.
- in_ready = !s1_valid || s2_load. The signal is combinational from out_ready, and there is no bubble at full throughput.
- Output retire: a result retires on an edge where out_valid && out_ready. While out_valid && !out_ready, y/nv/tag_out stay stable.
- Classification: exponent 0 means zero (denormals flush to zero, including their sign). ±0 compare equal.
- Ordering: sign-magnitude.
  - If both are zero, they are equal.
  - If the signs differ, the negative operand is less.
  - If both are positive, compare bits [30:0] unsigned.
  - If both are negative, the comparison is reversed.
- Result: FEQ gives eq, FLT gives lt, FLE gives lt||eq. Reserved op gives y=0, nv=0, and still produces a result with its tag.
- Reset mid-operation: both stages are invalidated immediately, and in-flight requests are dropped without a response.

## Timing
- Reset values: out_valid=0, y=0, nv=0, tag_out=0, internal valids=0. in_ready=1 during and after reset.
- Latency: a request accepted at edge k has out_valid=1 after edge k+1. The result is visible in the cycle following the S1→S2 transfer, so it is 2 cycles from in_valid assertion to out_valid with no stall.
- Throughput: 1 request/cycle while out_ready=1.
- Full: S1 and S2 valid with out_ready=0 gives in_ready=0. When out_ready rises, in_ready rises in the same cycle.
- Simultaneous accept and retire on a full pipe: S2 takes S1, S1 takes the new request, and nothing is lost or duplicated.
- Stalled S2 contents never change; S1 holds until s2_load.

## Configuration
- FCMP_NAN_EN defined: exponent 255 is classified.
  - Any NaN operand gives y=0.
  - nv=1 for FLT/FLE with any NaN, and for FEQ only with a signaling NaN (bit 22 = 0, mantissa ≠ 0).
  - ±inf orders normally.
- FCMP_NAN_EN undefined: exponent 255 gets no special handling and is ordered by bit pattern. The nv output is tied to 0.

## Test plan
- Zeros: FEQ 32'h80000000 vs 32'h00000000 → y=1. FLT of the same pair → y=0. FLE → y=1.
- Ordering: FLT 32'hBF800000 (-1.0) vs 32'h3F800000 (1.0) → y=1. FLT 32'hC0000000 vs 32'hBF800000 → y=1. FEQ 32'h3F800000 vs 32'h3F800001 → y=0.
- Throughput and tags: 8 back-to-back requests with tags 0–7 and out_ready=1 → out_valid from the 3rd cycle onward, tags 0–7 in order, and no gaps.
- Backpressure: out_ready=0 for 5 cycles during a stream → in_ready falls after 2 accepts, y/tag_out stay stable, and after release all results emerge in order with no loss or duplication.
- Reset: rstn pulsed low with both stages full → out_valid=0 asynchronously, and no stale result afterward.
- With FCMP_NAN_EN: FEQ 32'h7FC00000 vs itself → y=0, nv=0. FLE 32'h7FA00000 vs 1.0 → y=0, nv=1. Without the macro, nv always 0.
- Random: millions of finite/zero operand pairs with random op → match a shortreal reference model.
